aes_byte_serializer: RTL

- Downstream of the AES core: takes a finished 128-bit state word and emits it as 16 bytes, MSB byte first, on a valid/ready byte stream. This matches the byte-serial order the core uses on its input.
- Two-block buffer (active + pending), so the core can hand over the next block while the current one drains.
- Zero-bubble back-to-back output.

---
 rtl/aes_pkg.sv | 15 +
 rtl/aes_block_slot.sv | 28 ++
 rtl/aes_byte_serializer.sv | 106 ++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES block-path constants and the byte-serializer state encoding.
package aes_pkg;

    localparam int AES_BLOCK_BYTES = 16;
    localparam int AES_BLOCK_W     = 8 * AES_BLOCK_BYTES;

    localparam logic SER_IDLE = 1'b0;
    localparam logic SER_SEND = 1'b1;

    typedef enum logic {
        ST_IDLE = SER_IDLE,
        ST_SEND = SER_SEND
    } ser_state_e;

endpackage

// File: rtl/aes_block_slot.sv
// One-entry block holding register with a full flag; load fills it, take empties it.
module aes_block_slot
    import aes_pkg::*;
#(
    parameter int W = AES_BLOCK_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         take,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout <= '0;
            full <= 1'b0;
        end else if (load) begin
            dout <= din;
            full <= 1'b1;
        end else if (take) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/aes_byte_serializer.sv
// Serializes finished AES blocks into an MSB-first valid/ready byte stream,
// with one pending slot so the next block can queue while the current one drains.
//
// state | meaning
// IDLE  | no active block, waiting for blk_valid
// SEND  | active block being shifted out one byte per transfer
module aes_byte_serializer
    import aes_pkg::*;
#(
    parameter int NBYTES = AES_BLOCK_BYTES,
    parameter int CNT_W  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                blk_valid,
    input  logic [8*NBYTES-1:0] blk_data,
    output logic                blk_ready,
    output logic                byte_valid,
    output logic [7:0]          byte_data,
    input  logic                byte_ready,
    output logic                byte_last,
    output logic                busy
);

    localparam int BLK_W = 8 * NBYTES;

    ser_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [BLK_W-1:0] active_q, active_d;
    logic [BLK_W-1:0] pend_data;
    logic             pend_full;
    logic             pend_load, pend_take;
    logic             blk_acc, xfer, at_last;

    assign blk_ready  = ~pend_full;
    assign byte_valid = (state_q == ST_SEND);
    assign byte_data  = active_q[BLK_W-1 -: 8];
    assign at_last    = (count_q == CNT_W'(NBYTES - 1));
    assign byte_last  = byte_valid & at_last;
    assign busy       = byte_valid | pend_full;

    assign blk_acc = blk_valid & blk_ready;
    assign xfer    = byte_valid & byte_ready;

    aes_block_slot #(.W(BLK_W)) u_pending (
        .clk   (clk),
        .reset (reset),
        .load  (pend_load),
        .take  (pend_take),
        .din   (blk_data),
        .dout  (pend_data),
        .full  (pend_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            active_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        active_d  = active_q;
        pend_load = 1'b0;
        pend_take = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (blk_acc) begin
                    active_d = blk_data;
                    count_d  = '0;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (xfer && at_last) begin
                    // Reload without an idle cycle: pending first, else a block arriving now.
                    count_d = '0;
                    if (pend_full) begin
                        active_d  = pend_data;
                        pend_take = 1'b1;
                    end else if (blk_acc) begin
                        active_d = blk_data;
                    end else begin
                        active_d = '0;
                        state_d  = ST_IDLE;
                    end
                end else begin
                    if (xfer) begin
                        active_d = {active_q[BLK_W-9:0], 8'h00};
                        count_d  = count_q + CNT_W'(1);
                    end
                    pend_load = blk_acc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
